// File: rtl/btn_conditioner_if.sv
// Button-side signal bundle for btn_conditioner: the raw button level in and the
// debounced level plus event pulses out.
interface btn_conditioner_if;
    logic BTN_IN;
    logic BTN_LEVEL;
    logic PRESS_PULSE;
    logic RELEASE_PULSE;
    logic REPEAT_PULSE;
    logic EVENT;

    modport master (
        output BTN_IN,
        input  BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE, EVENT
    );

    modport slave (
        input  BTN_IN,
        output BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE, EVENT
    );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button synchronizer, debouncer and press/release/auto-repeat pulse generator.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    parameter int CNT_W           = 20
) (
    input  logic               CLK,
    input  logic               BTN_RST,
    btn_conditioner_if.slave   btn
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Bad parameters are rejected at elaboration rather than producing a silently
    // truncated compare value.
    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CNT_W < 1 ||
            longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W) ||
            longint'(REPEAT_DELAY)    >= (longint'(1) << CNT_W) ||
            longint'(REPEAT_PERIOD)   >= (longint'(1) << CNT_W)) begin : g_bad_params
            $error("btn_conditioner: parameter out of range");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    state_t           state;
    logic             s1;
    logic             s;
    logic [CNT_W-1:0] dcnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             event_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RDLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPER = CNT_W'(REPEAT_PERIOD);
    logic [CNT_W-1:0] rcnt;
    logic             period_ph;
    logic             repeat_q;
`endif

    always_ff @(posedge CLK) begin
        if (BTN_RST) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn.BTN_IN;
            s  <= s1;
        end
    end

    // Every pulse defaults low each cycle, so an event can only last one clock.
    always_ff @(posedge CLK) begin
        if (BTN_RST) begin
            state     <= IDLE;
            dcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt      <= '0;
            period_ph <= 1'b0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        dcnt  <= ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (dcnt == DMAX) begin
                        state   <= HELD;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        event_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt      <= '0;
                        period_ph <= 1'b0;
`endif
                    end else begin
                        dcnt <= sat_inc(dcnt);
                    end
                end
                HELD: begin
`ifdef BTN_AUTOREPEAT_EN
                    // The repeat timer also runs on the cycle that leaves for RELEASE_WAIT.
                    if ((!period_ph && rcnt == RDLY) || (period_ph && rcnt == RPER)) begin
                        repeat_q  <= 1'b1;
                        event_q   <= 1'b1;
                        rcnt      <= '0;
                        period_ph <= 1'b1;
                    end else begin
                        rcnt <= sat_inc(rcnt);
                    end
`endif
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= HELD;
                    end else if (dcnt == DMAX) begin
                        state     <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        dcnt <= sat_inc(dcnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign btn.BTN_LEVEL     = level_q;
    assign btn.PRESS_PULSE   = press_q;
    assign btn.RELEASE_PULSE = release_q;
    assign btn.EVENT         = event_q;
`ifdef BTN_AUTOREPEAT_EN
    assign btn.REPEAT_PULSE  = repeat_q;
`else
    assign btn.REPEAT_PULSE  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a run-length reference model predicts pulses,
// a negedge monitor pops and compares them. Honours BTN_AUTOREPEAT_EN like the design.
module tb_btn_conditioner;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;
    localparam int CW   = 20;

    typedef struct {
        int   cyc;
        logic press;
        logic rel;
        logic rep;
        logic evt;
    } exp_t;

    logic clk = 1'b0;
    logic btnRst = 1'b1;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .CNT_W           (CW)
    ) dut (
        .CLK     (clk),
        .BTN_RST (btnRst),
        .btn     (bus)
    );

    always #5 clk = ~clk;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   edgeCnt = 0;
    logic m1 = 1'b0;
    logic m2 = 1'b0;
    logic mLevel = 1'b0;
    logic mReset = 1'b1;
    int   run = 0;
    int   holdCnt = 0;
    int   lastRstEdge = 0;
    int   pressEdge = -1;
    int   evtCount = 0;
    int   pressCount = 0;
    int   releaseCount = 0;

    // Reference model: a level change is accepted once the synchronized input has
    // disagreed with the accepted level for DEB+1 samples in a row. Repeats fire on
    // the counts of "held and not disputed" edges since the press.
    initial begin
        forever begin
            logic sNow;
            logic wasActive;
            logic press;
            logic rel;
            logic rep;
            @(posedge clk);
            edgeCnt++;
            if (btnRst) begin
                m1 = 1'b0;
                m2 = 1'b0;
                mLevel = 1'b0;
                run = 0;
                holdCnt = 0;
                mReset = 1'b1;
            end else begin
                mReset = 1'b0;
                sNow = m2;
                m2 = m1;
                m1 = bus.BTN_IN;
                press = 1'b0;
                rel = 1'b0;
                rep = 1'b0;
                wasActive = mLevel && (run == 0);
                if (sNow != mLevel) run++;
                else run = 0;
                if (run == DEB + 1) begin
                    if (!mLevel) begin
                        press = 1'b1;
                        holdCnt = 0;
                    end else begin
                        rel = 1'b1;
                    end
                    mLevel = ~mLevel;
                    run = 0;
                end
`ifdef BTN_AUTOREPEAT_EN
                if (wasActive) begin
                    holdCnt++;
                    if (holdCnt == RDLY + 1 ||
                        (holdCnt > RDLY + 1 && (holdCnt - RDLY - 1) % (RPER + 1) == 0))
                        rep = 1'b1;
                end
`endif
                if (press || rel || rep)
                    expQ.push_back('{edgeCnt, press, rel, rep, press | rep});
            end
        end
    end

    task automatic checkOutput();
        logic [3:0] got;
        exp_t e;
        got = {bus.PRESS_PULSE, bus.RELEASE_PULSE, bus.REPEAT_PULSE, bus.EVENT};
        if (mReset) begin
            lastRstEdge = edgeCnt;
            tests++;
            if ({bus.BTN_LEVEL, got} !== 5'b0) begin
                fails++;
                $display("[TB] FAIL reset_outputs @%0d: got %b expected 00000", edgeCnt, {bus.BTN_LEVEL, got});
            end
        end else begin
            tests++;
            if (bus.BTN_LEVEL !== mLevel) begin
                fails++;
                $display("[TB] FAIL level @%0d: got %b expected %b", edgeCnt, bus.BTN_LEVEL, mLevel);
            end
        end
        while (expQ.size() > 0 && expQ[0].cyc < edgeCnt) begin
            e = expQ.pop_front();
            tests++;
            fails++;
            $display("[TB] FAIL missed_pulse: expected press/rel/rep/evt %b%b%b%b at edge %0d, got none",
                     e.press, e.rel, e.rep, e.evt, e.cyc);
        end
        if (got !== 4'b0) begin
            if (bus.EVENT === 1'b1) evtCount++;
            if (bus.PRESS_PULSE === 1'b1) begin
                pressCount++;
                pressEdge = edgeCnt;
            end
            if (bus.RELEASE_PULSE === 1'b1) releaseCount++;
            tests++;
            if (expQ.size() == 0 || expQ[0].cyc != edgeCnt) begin
                fails++;
                $display("[TB] FAIL unexpected_pulse @%0d: got %b expected 0000", edgeCnt, got);
            end else begin
                e = expQ.pop_front();
                if (got !== {e.press, e.rel, e.rep, e.evt}) begin
                    fails++;
                    $display("[TB] FAIL pulse_bits @%0d: got %b expected %b%b%b%b",
                             edgeCnt, got, e.press, e.rel, e.rep, e.evt);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    // Each call makes exactly n rising edges sample the given reset/button values.
    task automatic applyStimulus(input logic rst, input logic lvl, input int n);
        repeat (n) begin
            @(negedge clk);
            btnRst = rst;
            bus.BTN_IN = lvl;
        end
    endtask

    initial begin
        int base;
        int pbase;
        int rbase;
        bus.BTN_IN = 1'b0;

        // Reset held with the button pressed; the press must land DEB+2 edges after
        // the first non-reset edge, i.e. DEB+3 after the last reset edge.
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 12);
        tests++;
        if (pressEdge - lastRstEdge != DEB + 3) begin
            fails++;
            $display("[TB] FAIL press_latency: got %0d edges expected %0d", pressEdge - lastRstEdge, DEB + 3);
        end
        applyStimulus(1'b0, 1'b0, 12);

        // Bounce shorter than the debounce window must produce nothing.
        base = evtCount;
        rbase = releaseCount;
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 12);
        tests++;
        if (evtCount != base || releaseCount != rbase) begin
            fails++;
            $display("[TB] FAIL bounce_pulses: got %0d events %0d releases expected 0 0",
                     evtCount - base, releaseCount - rbase);
        end

        // Clean press/release.
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 12);

        // Auto-repeat: 60-cycle hold gives one press plus four repeats when enabled.
        base = evtCount;
        applyStimulus(1'b0, 1'b1, 60);
        applyStimulus(1'b0, 1'b0, 12);
        tests++;
`ifdef BTN_AUTOREPEAT_EN
        if (evtCount - base != 5) begin
            fails++;
            $display("[TB] FAIL repeat_events: got %0d expected 5", evtCount - base);
        end
`else
        if (evtCount - base != 1) begin
            fails++;
            $display("[TB] FAIL repeat_events: got %0d expected 1", evtCount - base);
        end
`endif

        // Release glitch while held: one press and one release over the whole episode.
        pbase = pressCount;
        rbase = releaseCount;
        applyStimulus(1'b0, 1'b1, 30);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 30);
        applyStimulus(1'b0, 1'b0, 12);
        tests++;
        if (pressCount - pbase != 1 || releaseCount - rbase != 1) begin
            fails++;
            $display("[TB] FAIL glitch_counts: got %0d presses %0d releases expected 1 1",
                     pressCount - pbase, releaseCount - rbase);
        end

        // Random segments: occasional resets, short glitches and long holds.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            else if (r < 40)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, DEB + 1));
            else
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 60));
        end

        applyStimulus(1'b0, 1'b0, 15);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL leftover_expected: got %0d pending expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
